// File: rtl/kid_life_controller.sv
// kid_life_controller: per-player life/death/respawn/game-over sequencer driving the Kid datapath reset and checkpoint.
module kid_life_controller #(
  parameter logic [9:0] START_X      = 10'd32,
  parameter logic [9:0] START_Y      = 10'd415,
  parameter logic [2:0] LIVES        = 3'd3,
  parameter logic [7:0] DEATH_FRAMES = 8'd60
) (
  input  logic       frame_clk,
  input  logic       Reset_h,
  input  logic       collide,
  input  logic       Ground,
  input  logic       Key_R,
  input  logic       Key_G,
  input  logic [9:0] PositionX,
  input  logic [9:0] PositionY,
  output logic       Kid_reset,
  output logic [9:0] Reset_X,
  output logic [9:0] Reset_Y,
  output logic [2:0] lives,
  output logic       dying,
  output logic       game_over,
  output logic       saved
);
  typedef enum logic [2:0] {BOOT, PLAY, DYING, RESPAWN, GAME_OVER} state_e;
  state_e     state_q;
  logic [9:0] reset_x_q, reset_y_q;
  logic [2:0] lives_q;
  logic [7:0] count_q;
  logic       saved_q, key_r_q, key_g_q;
  logic       r_press, g_press;
  assign r_press = Key_R & ~key_r_q;
  assign g_press = Key_G & ~key_g_q;
  always_ff @(posedge frame_clk or posedge Reset_h) begin
    if (Reset_h) begin
      state_q   <= BOOT;
      reset_x_q <= START_X;
      reset_y_q <= START_Y;
      lives_q   <= LIVES;
      count_q   <= 8'd0;
      saved_q   <= 1'b0;
      key_r_q   <= 1'b1;
      key_g_q   <= 1'b1;
    end else begin
      key_r_q <= Key_R;
      key_g_q <= Key_G;
      saved_q <= 1'b0;
      case (state_q)
        BOOT: state_q <= PLAY;
        PLAY: begin
          if (collide) begin
            lives_q <= lives_q - 3'd1;
            count_q <= DEATH_FRAMES - 8'd1;
            state_q <= DYING;
          end else if (r_press) begin
            state_q <= RESPAWN;
          end else if (g_press && Ground) begin
            reset_x_q <= PositionX;
            reset_y_q <= PositionY;
            saved_q   <= 1'b1;
          end
        end
        DYING: begin
          if (count_q == 8'd0) state_q <= (lives_q == 3'd0) ? GAME_OVER : RESPAWN;
          else count_q <= count_q - 8'd1;
        end
        RESPAWN: state_q <= PLAY;
        GAME_OVER: begin
          if (r_press) begin
            lives_q   <= LIVES;
            reset_x_q <= START_X;
            reset_y_q <= START_Y;
            state_q   <= RESPAWN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end
  assign Kid_reset = (state_q == BOOT) || (state_q == RESPAWN) || (state_q == GAME_OVER);
  assign dying     = (state_q == DYING);
  assign game_over = (state_q == GAME_OVER);
  assign saved     = saved_q;
  assign lives     = lives_q;
  assign Reset_X   = reset_x_q;
  assign Reset_Y   = reset_y_q;
endmodule

// File: tb/tb_kid_life_controller.sv
// tb_kid_life_controller: scenario tasks push expected outputs to a scoreboard and compare them after each frame edge.
module tb_kid_life_controller;
  logic       frame_clk = 1'b0, Reset_h = 1'b1, collide = 1'b0, Ground = 1'b0, Key_R = 1'b0, Key_G = 1'b0;
  logic [9:0] PositionX = 10'd0, PositionY = 10'd0;
  logic       Kid_reset, dying, game_over, saved;
  logic [9:0] Reset_X, Reset_Y;
  logic [2:0] lives;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic       kr, dy, go, sv;
    logic [2:0] lv;
    logic [9:0] x, y;
  } exp_t;
  exp_t sb[$];
  exp_t got, want;
  always #5 frame_clk = ~frame_clk;
  kid_life_controller dut (
    .frame_clk(frame_clk), .Reset_h(Reset_h), .collide(collide), .Ground(Ground),
    .Key_R(Key_R), .Key_G(Key_G), .PositionX(PositionX), .PositionY(PositionY),
    .Kid_reset(Kid_reset), .Reset_X(Reset_X), .Reset_Y(Reset_Y), .lives(lives),
    .dying(dying), .game_over(game_over), .saved(saved)
  );
  function automatic exp_t mk(logic kr, logic dy, logic go, logic sv, logic [2:0] lv, logic [9:0] x, logic [9:0] y);
    return {kr, dy, go, sv, lv, x, y};
  endfunction
  function automatic exp_t obs();
    return {Kid_reset, dying, game_over, saved, lives, Reset_X, Reset_Y};
  endfunction
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) tick();
    sb.push_back(mk(1, 0, 0, 0, 3, 32, 415));
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_hold got=%h want=%h", got, want); end
    Reset_h = 1'b0;
    sb.push_back(mk(1, 0, 0, 0, 3, 32, 415));
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL boot got=%h want=%h", got, want); end
    sb.push_back(mk(0, 0, 0, 0, 3, 32, 415));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL play_after_boot got=%h want=%h", got, want); end
  endtask
  task automatic test_save();
    Ground = 1'b1; PositionX = 10'd200; PositionY = 10'd300; Key_G = 1'b1;
    sb.push_back(mk(0, 0, 0, 1, 3, 200, 300));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL save_pulse got=%h want=%h", got, want); end
    sb.push_back(mk(0, 0, 0, 0, 3, 200, 300));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL save_pulse_end got=%h want=%h", got, want); end
    Key_G = 1'b0;
    tick();
    Ground = 1'b0; PositionX = 10'd100; PositionY = 10'd100; Key_G = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 3, 200, 300));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL save_airborne got=%h want=%h", got, want); end
    Key_G = 1'b0;
    tick();
  endtask
  task automatic test_death();
    collide = 1'b1;
    sb.push_back(mk(0, 1, 0, 0, 2, 200, 300));
    tick();
    collide = 1'b0;
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL death_start got=%h want=%h", got, want); end
    for (int i = 1; i < 60; i++) begin
      Key_R = (i == 10); Key_G = (i == 10); Ground = 1'b1; collide = (i == 20);
      PositionX = 10'd7; PositionY = 10'd9;
      sb.push_back(mk(0, 1, 0, 0, 2, 200, 300));
      tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL dying_cycle_%0d got=%h want=%h", i, got, want); end
    end
    Key_R = 1'b0; Key_G = 1'b0; collide = 1'b0;
    sb.push_back(mk(1, 0, 0, 0, 2, 200, 300));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL death_respawn got=%h want=%h", got, want); end
    sb.push_back(mk(0, 0, 0, 0, 2, 200, 300));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL death_play got=%h want=%h", got, want); end
  endtask
  task automatic test_game_over();
    for (int d = 0; d < 2; d++) begin
      collide = 1'b1;
      tick();
      collide = 1'b0;
      sb.push_back(mk(0, 1, 0, 0, 3'(1 - d), 200, 300));
      repeat (59) tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL go_last_dying_%0d got=%h want=%h", d, got, want); end
      sb.push_back(d == 0 ? mk(1, 0, 0, 0, 1, 200, 300) : mk(1, 0, 1, 0, 0, 200, 300));
      tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL go_after_death_%0d got=%h want=%h", d, got, want); end
      if (d == 0) tick();
    end
    for (int i = 0; i < 4; i++) begin
      collide = (i < 2); Key_G = (i == 1); Ground = 1'b1;
      sb.push_back(mk(1, 0, 1, 0, 0, 200, 300));
      tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL go_hold_%0d got=%h want=%h", i, got, want); end
    end
    collide = 1'b0; Key_G = 1'b0; Key_R = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 3, 32, 415));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL go_restart got=%h want=%h", got, want); end
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 3, 32, 415));
      tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL go_play_%0d got=%h want=%h", i, got, want); end
    end
    Key_R = 1'b0;
    tick();
  endtask
  task automatic test_priority();
    Ground = 1'b1; PositionX = 10'd50; PositionY = 10'd60;
    collide = 1'b1; Key_R = 1'b1; Key_G = 1'b1;
    sb.push_back(mk(0, 1, 0, 0, 2, 32, 415));
    tick();
    collide = 1'b0; Key_R = 1'b0; Key_G = 1'b0;
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL prio_dying got=%h want=%h", got, want); end
    repeat (59) tick();
    sb.push_back(mk(1, 0, 0, 0, 2, 32, 415));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL prio_respawn got=%h want=%h", got, want); end
    tick();
  endtask
  task automatic test_back_to_back();
    Key_R = 1'b1;
    sb.push_back(mk(1, 0, 0, 0, 2, 32, 415));
    tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL rheld_respawn got=%h want=%h", got, want); end
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 2, 32, 415));
      tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL rheld_play_%0d got=%h want=%h", i, got, want); end
    end
    Key_R = 1'b0;
    tick();
  endtask
  task automatic test_async_reset();
    Ground = 1'b1; PositionX = 10'd120; PositionY = 10'd140; Key_G = 1'b1;
    tick();
    Key_G = 1'b0;
    collide = 1'b1;
    tick();
    collide = 1'b0;
    sb.push_back(mk(0, 1, 0, 0, 1, 120, 140));
    repeat (29) tick();
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL ar_dying got=%h want=%h", got, want); end
    Key_R = 1'b1;
    #2;
    Reset_h = 1'b1;
    #1;
    sb.push_back(mk(1, 0, 0, 0, 3, 32, 415));
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL ar_immediate got=%h want=%h", got, want); end
    tick();
    Reset_h = 1'b0;
    sb.push_back(mk(1, 0, 0, 0, 3, 32, 415));
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL ar_boot got=%h want=%h", got, want); end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 3, 32, 415));
      tick();
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ar_play_keyheld_%0d got=%h want=%h", i, got, want); end
    end
    Key_R = 1'b0;
  endtask
  initial begin
    test_reset();
    test_save();
    test_death();
    test_game_over();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
